// File: rtl/dmem_responder.sv
// Data memory responder: a single-outstanding load/store slave with a fixed number
// of wait states, byte-lane stores and an out-of-range error flag.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_enable,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int unsigned DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;

    logic        req_read, req_write;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        cmt_read, cmt_write;
    logic [29:0] cmt_addr;
    logic [31:0] cmt_wdata;
    logic [3:0]  cmt_be;
    logic        in_range;
    logic        accept;
    logic        go_resp;

    logic [31:0] mem [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign accept = (state == IDLE) && (read || write);

    // Next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (read || write) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = RESP;
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (state == RESP);
        busy  = accept || (state == WAIT);
    end

    // A zero-wait access commits on its accept edge, before the capture registers
    // hold it, so the commit path takes the live inputs while still in IDLE.
    always_comb begin
        if (state == IDLE) begin
            cmt_read  = read;
            cmt_write = write;
            cmt_addr  = addr;
            cmt_wdata = wdata;
            cmt_be    = byte_enable;
        end else begin
            cmt_read  = req_read;
            cmt_write = req_write;
            cmt_addr  = req_addr;
            cmt_wdata = req_wdata;
            cmt_be    = req_be;
        end
    end

    assign in_range = ((cmt_addr >> DEPTH_LOG2) == '0);
    assign go_resp  = (state != RESP) && (state_next == RESP);

    // Request capture, store commit and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                req_read  <= read;
                req_write <= write;
                req_addr  <= addr;
                req_wdata <= wdata;
                req_be    <= byte_enable;
            end
            rdata <= '0;
            err   <= 1'b0;
            if (go_resp) begin
                err <= !in_range;
                if (in_range) begin
                    if (cmt_read) rdata <= mem[cmt_addr[DEPTH_LOG2-1:0]];
                    if (cmt_write) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (cmt_be[i])
                                mem[cmt_addr[DEPTH_LOG2-1:0]][8*i +: 8] <= cmt_wdata[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES=2, DEPTH_LOG2=8.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        read, write;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_enable;
    logic [31:0] rdata;
    logic        ready, busy, err;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .byte_enable(byte_enable), .rdata(rdata),
        .ready(ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access; when stray is set, a conflicting store is driven during the wait.
    task automatic access(input vec_t v, input bit stray);
        int busy_cnt;
        bit seen;
        @(negedge clk);
        read = v.rd; write = v.wr; addr = v.a; wdata = v.wd; byte_enable = v.be;
        #1;
        check("busy_on_request", {31'd0, busy}, 32'd1);
        busy_cnt = 1;
        @(posedge clk); #1;
        if (stray) begin
            read = 1'b0; write = 1'b1; addr = v.a; wdata = 32'h0; byte_enable = 4'hF;
        end else begin
            read = 1'b0; write = 1'b0; addr = '0; wdata = '0; byte_enable = '0;
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ready) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            check("wait_rdata_zero", rdata, 32'h0);
            @(posedge clk); #1;
        end
        check("ready_seen", {31'd0, seen}, 32'd1);
        read = 1'b0; write = 1'b0; addr = '0; wdata = '0; byte_enable = '0;
        check("busy_cycles", busy_cnt, 3);
        check("resp_busy", {31'd0, busy}, 32'd0);
        check("resp_rdata", rdata, v.exp_rdata);
        check("resp_err", {31'd0, err}, {31'd0, v.exp_err});
        @(posedge clk); #1;
        check("post_ready", {31'd0, ready}, 32'd0);
        check("post_rdata", rdata, 32'h0);
        check("post_err", {31'd0, err}, 32'd0);
    endtask

    function automatic vec_t mk(logic rd, logic wr, logic [29:0] a, logic [31:0] wd,
                                logic [3:0] be, logic [31:0] er, logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.be = be;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(0, 1, 30'd5,         32'hDEADBEEF, 4'hF, 32'h0,        0);
        vecs[1]  = mk(1, 0, 30'd5,         32'h0,        4'h0, 32'hDEADBEEF, 0);
        vecs[2]  = mk(0, 1, 30'd5,         32'h0000AA00, 4'h2, 32'h0,        0);
        vecs[3]  = mk(1, 0, 30'd5,         32'h0,        4'h0, 32'hDEADAAEF, 0);
        vecs[4]  = mk(0, 1, 30'd0,         32'h55AA55AA, 4'hF, 32'h0,        0);
        vecs[5]  = mk(1, 0, 30'h100,       32'h0,        4'h0, 32'h0,        1);
        vecs[6]  = mk(0, 1, 30'h100,       32'h12345678, 4'hF, 32'h0,        1);
        vecs[7]  = mk(1, 0, 30'd0,         32'h0,        4'h0, 32'h55AA55AA, 0);
        vecs[8]  = mk(0, 1, 30'd9,         32'hCAFEF00D, 4'hF, 32'h0,        0);
        vecs[9]  = mk(1, 1, 30'd9,         32'h0BADBEEF, 4'hF, 32'hCAFEF00D, 0);
        vecs[10] = mk(1, 0, 30'd9,         32'h0,        4'h0, 32'h0BADBEEF, 0);
        vecs[11] = mk(0, 1, 30'd5,         32'hFFFFFFFF, 4'h0, 32'h0,        0);
        vecs[12] = mk(1, 0, 30'd5,         32'h0,        4'h0, 32'hDEADAAEF, 0);
        vecs[13] = mk(0, 1, 30'd3,         32'hA5A5A5A5, 4'hF, 32'h0,        0);
        vecs[14] = mk(0, 1, 30'd3,         32'h12345678, 4'h5, 32'h0,        0);
        vecs[15] = mk(1, 0, 30'h3FFFFFFF,  32'h0,        4'h0, 32'h0,        1);

        rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0; byte_enable = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_err",   {31'd0, err},   32'd0);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) access(vecs[i], 1'b0);

        // Partial store on word 3 merged lanes 0 and 2.
        access(mk(1, 0, 30'd3, 32'h0, 4'h0, 32'hA534A578, 0), 1'b0);

        // Requests seen while an access is pending must be ignored.
        access(mk(1, 0, 30'd3, 32'h0, 4'h0, 32'hA534A578, 0), 1'b1);
        access(mk(1, 0, 30'd3, 32'h0, 4'h0, 32'hA534A578, 0), 1'b0);

        // Reset during WAIT cancels an uncommitted store.
        access(mk(0, 1, 30'd7, 32'h11111111, 4'hF, 32'h0, 0), 1'b0);
        @(negedge clk);
        write = 1'b1; addr = 30'd7; wdata = 32'h00000001; byte_enable = 4'hF;
        @(posedge clk); #1;
        write = 1'b0; addr = '0; wdata = '0; byte_enable = '0;
        check("wait_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstwait_ready", {31'd0, ready}, 32'd0);
        check("rstwait_busy",  {31'd0, busy},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rstwait_no_ready", {31'd0, ready}, 32'd0);
        end
        access(mk(1, 0, 30'd7, 32'h0, 4'h0, 32'h11111111, 0), 1'b0);

        // Reset coincident with an IDLE request drops it.
        @(negedge clk);
        rst = 1'b1; write = 1'b1; addr = 30'd7; wdata = 32'h0; byte_enable = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0; write = 1'b0; addr = '0; byte_enable = '0;
        for (int k = 0; k < 4; k++) begin
            check("dropped_no_ready", {31'd0, ready}, 32'd0);
            @(posedge clk); #1;
        end
        access(mk(1, 0, 30'd7, 32'h0, 4'h0, 32'h11111111, 0), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
